// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, NOP encoding, fetch FSM
// encoding, the IF/ID entry record and the sequential-PC helper.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer that catches a returned instruction while decode is stalled.
// Flush beats load, load beats unload.
module fetch_skid
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic         valid_o,
    output fetch_entry_t entry_o
);

    logic         valid_q, valid_d;
    fetch_entry_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding request, IF/ID register, skid buffer.
// state  | meaning:  S_REQ = request pending / may issue,  S_WAIT = one request outstanding
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              stall,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         drop_q, drop_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_inst_q, id_inst_d;

    logic         req_valid;
    logic         req_fire;
    logic         rsp_in;
    logic         rsp_use;
    logic         id_free;
    logic         skid_valid;
    logic         skid_load;
    logic         skid_unload;
    fetch_entry_t skid_entry;
    fetch_entry_t rsp_entry;

    assign req_fire  = req_valid & imem.imem_req_ready;
    assign rsp_in    = (state_q == S_WAIT) & imem.imem_rsp_valid;
    assign rsp_use   = rsp_in & ~drop_q & ~branch_taken;
    assign id_free   = ~id_valid_q | ~stall;
    assign rsp_entry = '{pc: req_pc_q, inst: imem.imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect never changes the state: an outstanding request stays outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (req_fire)             state_d = S_WAIT;
            S_WAIT:  if (imem.imem_rsp_valid)  state_d = S_REQ;
            default:                           state_d = S_REQ;
        endcase
    end

    always_comb begin
        req_valid = 1'b0;
        if (!rst && state_q == S_REQ && !skid_valid) begin
            req_valid = 1'b1;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = next_pc(pc_q);
        end
        if (branch_taken) begin
            pc_d = branch_target & 32'hFFFF_FFFC;
        end
        if (rsp_in) begin
            drop_d = 1'b0;
        end
        // The in-flight word belongs to the old path and must be thrown away on arrival.
        if (branch_taken && ((state_q == S_WAIT && !imem.imem_rsp_valid) || req_fire)) begin
            drop_d = 1'b1;
        end
    end

    always_comb begin
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        if (branch_taken) begin
            id_valid_d = 1'b0;
            id_inst_d  = INST_NOP;
        end else if (id_free) begin
            if (skid_valid) begin
                id_valid_d  = 1'b1;
                id_pc_d     = skid_entry.pc;
                id_inst_d   = skid_entry.inst;
                skid_unload = 1'b1;
            end else if (rsp_use) begin
                id_valid_d = 1'b1;
                id_pc_d    = rsp_entry.pc;
                id_inst_d  = rsp_entry.inst;
            end else begin
                id_valid_d = 1'b0;
            end
        end else if (rsp_use) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'd0;
            drop_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_inst_q  <= INST_NOP;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (branch_taken),
        .entry_i  (rsp_entry),
        .valid_o  (skid_valid),
        .entry_o  (skid_entry)
    );

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-stream reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        stall = 1'b0;
    logic        id_valid, id_valid2;
    logic [31:0] id_pc, id_inst, id_pc2, id_inst2;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 1;
    bit          spur_en = 1'b0;
    int          cyc = 0;
    logic [31:0] salt = 32'h1234_5678;

    fetch_unit_if imem ();
    fetch_unit_if imem2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(imem),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .imem(imem2),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .id_valid(id_valid2), .id_pc(id_pc2), .id_inst(id_inst2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Memory for dut: fixed latency from handshake, cleared by the shared reset,
    // optional junk responses while nothing is outstanding.
    initial begin
        logic [31:0] pend_addr[$];
        int          pend_due[$];
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else if (imem.imem_req_valid && imem.imem_req_ready) begin
                pend_addr.push_back(imem.imem_req_addr);
                pend_due.push_back(cyc + mem_lat);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else if (spur_en && pend_due.size() == 0 && $urandom_range(0, 3) == 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = 32'hDEAD_BEEF;
            end else begin
                imem.imem_rsp_valid = 1'b0;
                imem.imem_rsp_data  = $urandom();
            end
        end
    end

    // Memory for dut_wrap: always ready, one-cycle latency.
    initial begin
        logic        hs2;
        logic [31:0] a2;
        imem2.imem_req_ready = 1'b1;
        imem2.imem_rsp_valid = 1'b0;
        imem2.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            hs2 = !rst && imem2.imem_req_valid && imem2.imem_req_ready;
            a2  = imem2.imem_req_addr;
            @(posedge clk);
            #1;
            imem2.imem_rsp_valid = hs2;
            imem2.imem_rsp_data  = mem_word(a2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        imem.imem_req_ready = 1'b1;
        spur_en = 1'b0;
        mem_lat = 1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        imem.imem_req_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem.imem_req_valid); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        checks++; if (id_pc !== 32'd0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        checks++; if (id_inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_id_inst: got %h want 00000013", id_inst); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'd0) begin
            errors++; $display("FAIL reset_first_req: got valid=%b addr=%h want 1/00000000", imem.imem_req_valid, imem.imem_req_addr);
        end
        checks++; if (imem2.imem_req_valid !== 1'b1 || imem2.imem_req_addr !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL reset_first_req_wrap: got valid=%b addr=%h want 1/fffffff8", imem2.imem_req_valid, imem2.imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        bit          prev_rsp = 1'b0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem.imem_req_valid && imem.imem_req_ready) addrs.push_back(imem.imem_req_addr);
            if (id_valid) begin
                pcs.push_back(id_pc);
                checks++; if (id_inst !== mem_word(id_pc)) begin errors++; $display("FAIL seq_inst: pc=%h got %h want %h", id_pc, id_inst, mem_word(id_pc)); end
            end
            if (prev_rsp) begin
                checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_latency: id_valid got %b want 1 one cycle after response", id_valid); end
            end
            prev_rsp = imem.imem_rsp_valid;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (addrs.size() <= k) begin errors++; $display("FAIL seq_addr%0d: missing, want %h", k, 32'(4 * k)); end
            else if (addrs[k] !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", k, addrs[k], 32'(4 * k)); end
            checks++;
            if (pcs.size() <= k) begin errors++; $display("FAIL seq_id_pc%0d: missing, want %h", k, 32'(4 * k)); end
            else if (pcs[k] !== 32'(4 * k)) begin errors++; $display("FAIL seq_id_pc%0d: got %h want %h", k, pcs[k], 32'(4 * k)); end
        end
    endtask

    task automatic test_stall();
        bit          seen = 1'b0;
        logic [31:0] p0, i0, nxt;
        int          got = 0;
        apply_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (id_valid) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_first_valid: id_valid never rose within 10 cycles"); return; end
        p0 = id_pc;
        i0 = id_inst;
        checks++; if (p0 !== 32'd0) begin errors++; $display("FAIL stall_first_pc: got %h want 00000000", p0); end
        for (int j = 1; j <= 2; j++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b1 || id_pc !== p0 || id_inst !== i0) begin
                errors++; $display("FAIL stall_frozen%0d: got %b/%h/%h want 1/%h/%h", j, id_valid, id_pc, id_inst, p0, i0);
            end
        end
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_skid_blocks_req: req_valid got %b want 0", imem.imem_req_valid); end
        tick();
        stall = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== p0) begin errors++; $display("FAIL stall_release_hold: got %b/%h want 1/%h", id_valid, id_pc, p0); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== p0 + 32'd4 || id_inst !== mem_word(p0 + 32'd4)) begin
            errors++; $display("FAIL stall_skid_out: got %b/%h/%h want 1/%h/%h", id_valid, id_pc, id_inst, p0 + 32'd4, mem_word(p0 + 32'd4));
        end
        nxt = p0 + 32'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (id_valid) begin
                checks++; if (id_pc !== nxt || id_inst !== mem_word(nxt)) begin
                    errors++; $display("FAIL stall_order: got %h/%h want %h/%h", id_pc, id_inst, nxt, mem_word(nxt));
                end
                nxt += 32'd4;
                got++;
            end
        end
        checks++; if (got < 2) begin errors++; $display("FAIL stall_progress: got %0d words want >=2", got); end
    endtask

    task automatic test_branch();
        bit          found = 1'b0;
        bit          got = 1'b0;
        bit          have_addr = 1'b0;
        logic [31:0] first_addr = 32'd0;
        apply_reset();
        mem_lat = 3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem.imem_req_valid && imem.imem_req_ready) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL br_first_hs: no handshake within 10 cycles"); return; end
        tick();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0000_0013) begin errors++; $display("FAIL br_flush: got %b/%h want 0/00000013", id_valid, id_inst); end
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL br_wait_drop: req_valid got %b want 0", imem.imem_req_valid); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!have_addr && imem.imem_req_valid && imem.imem_req_ready) begin have_addr = 1'b1; first_addr = imem.imem_req_addr; end
            if (id_valid) begin got = 1'b1; break; end
        end
        checks++; if (!have_addr || first_addr !== 32'h0000_0100) begin errors++; $display("FAIL br_next_addr: got %h (seen=%b) want 00000100", first_addr, have_addr); end
        checks++; if (!got) begin errors++; $display("FAIL br_timeout: no instruction within 20 cycles"); end
        else if (id_pc !== 32'h0000_0100 || id_inst !== mem_word(32'h0000_0100)) begin
            errors++; $display("FAIL br_first_word: got %h/%h want 00000100/%h", id_pc, id_inst, mem_word(32'h0000_0100));
        end
    endtask

    task automatic test_ready_low();
        bit found = 1'b0;
        apply_reset();
        imem.imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'd0) begin
                errors++; $display("FAIL rdy_hold%0d: got %b/%h want 1/00000000", i, imem.imem_req_valid, imem.imem_req_addr);
            end
            tick();
        end
        imem.imem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'd0) begin
            errors++; $display("FAIL rdy_accept: got %b/%h want 1/00000000", imem.imem_req_valid, imem.imem_req_addr);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (imem.imem_req_valid) begin found = 1'b1; break; end
        end
        checks++; if (!found || imem.imem_req_addr !== 32'd4) begin errors++; $display("FAIL rdy_next_addr: got %h (seen=%b) want 00000004", imem.imem_req_addr, found); end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        logic [31:0] exp_a[3];
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem2.imem_req_valid && imem2.imem_req_ready) addrs.push_back(imem2.imem_req_addr);
            if (id_valid2) begin
                pcs.push_back(id_pc2);
                checks++; if (id_inst2 !== mem_word(id_pc2)) begin errors++; $display("FAIL wrap_inst: pc=%h got %h want %h", id_pc2, id_inst2, mem_word(id_pc2)); end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (addrs.size() <= k || addrs[k] !== exp_a[k]) begin
                errors++; $display("FAIL wrap_addr%0d: got %h (n=%0d) want %h", k, (addrs.size() > k) ? addrs[k] : 32'hx, addrs.size(), exp_a[k]);
            end
            checks++;
            if (pcs.size() <= k || pcs[k] !== exp_a[k]) begin
                errors++; $display("FAIL wrap_id_pc%0d: got %h (n=%0d) want %h", k, (pcs.size() > k) ? pcs[k] : 32'hx, pcs.size(), exp_a[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        bit got = 1'b0;
        apply_reset();
        mem_lat = 3;
        stall = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (id_valid && imem.imem_req_valid && imem.imem_req_ready) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_setup: no valid+handshake within 15 cycles"); return; end
        tick();
        @(negedge clk);
        checks++; if (imem.imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin errors++; $display("FAIL rmid_wait: got req=%b id=%b want 0/1", imem.imem_req_valid, id_valid); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req_in_rst: got %b want 0", imem.imem_req_valid); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_inst !== 32'h0000_0013) begin
            errors++; $display("FAIL rmid_id: got %b/%h/%h want 0/00000000/00000013", id_valid, id_pc, id_inst);
        end
        checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'd0) begin
            errors++; $display("FAIL rmid_req: got %b/%h want 1/00000000", imem.imem_req_valid, imem.imem_req_addr);
        end
        tick();
        stall = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (id_valid) begin got = 1'b1; break; end
        end
        checks++; if (!got || id_pc !== 32'd0 || id_inst !== mem_word(32'd0)) begin
            errors++; $display("FAIL rmid_restart: got %b/%h/%h want 1/00000000/%h", got, id_pc, id_inst, mem_word(32'd0));
        end
    endtask

    // Reference: decode must see consecutive words starting at the reset PC or the
    // latest redirect target; a word sitting in ID during a redirect is squashed.
    task automatic test_random();
        for (int seg = 1; seg <= 3; seg++) begin
            logic [31:0] exp_pc = 32'd0;
            logic [31:0] prev_addr = 32'd0;
            bit          prev_wait = 1'b0;
            int          consumed = 0;
            apply_reset();
            mem_lat = seg;
            spur_en = 1'b1;
            for (int i = 0; i < 300; i++) begin
                stall = ($urandom_range(0, 99) < 30);
                imem.imem_req_ready = ($urandom_range(0, 99) < 70);
                branch_taken = ($urandom_range(0, 99) < 6);
                branch_target = $urandom_range(0, 1023);
                @(negedge clk);
                if (prev_wait) begin
                    checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== prev_addr) begin
                        errors++; $display("FAIL rand_req_stable: got %b/%h want 1/%h", imem.imem_req_valid, imem.imem_req_addr, prev_addr);
                    end
                end
                if (branch_taken) begin
                    exp_pc = branch_target & 32'hFFFF_FFFC;
                end else if (id_valid && !stall) begin
                    checks++; if (id_pc !== exp_pc || id_inst !== mem_word(exp_pc)) begin
                        errors++; $display("FAIL rand_stream: lat=%0d got %h/%h want %h/%h", seg, id_pc, id_inst, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc += 32'd4;
                    consumed++;
                end
                prev_wait = imem.imem_req_valid && !imem.imem_req_ready && !branch_taken;
                prev_addr = imem.imem_req_addr;
                tick();
            end
            checks++; if (consumed < 10) begin errors++; $display("FAIL rand_progress: lat=%0d consumed %0d want >=10", seg, consumed); end
        end
        spur_en = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        imem.imem_req_ready = 1'b1;
    endtask

    initial begin
        salt = $urandom();
        imem.imem_req_ready = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_ready_low();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: imem_req_valid  out  1  fetch request valid.
REQ-005 SHALL have port: imem_req_ready  in  1  memory accepts request.
REQ-006 SHALL have port: imem_req_addr  out  32  fetch address, equal to internal PC.
REQ-007 SHALL have port: imem_rsp_valid  in  1  instruction word returned.
REQ-008 SHALL have port: imem_rsp_data  in  32  instruction word.
REQ-009 SHALL have port: branch_taken  in  1  redirect request from execute.
REQ-010 SHALL have port: branch_target  in  32  redirect address.
REQ-011 SHALL have port: stall  in  1  decode cannot consume id_* this cycle.
REQ-012 SHALL have port: id_valid  out  1  IF/ID register holds a valid instruction.
REQ-013 SHALL have port: id_pc  out  32  PC of id_inst.
REQ-014 SHALL have port: id_inst  out  32  instruction to decode/immediate generator.

Function
REQ-015 SHALL implement states S_REQ (request pending) and S_WAIT (one request outstanding); at most one outstanding request.
REQ-016 SHALL assert imem_req_valid only in S_REQ with skid buffer empty; addr and valid held stable until imem_req_ready.
REQ-017 SHALL, on handshake (valid & ready), record req_pc <= pc, set pc <= pc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), go S_WAIT.
REQ-018 SHALL, in S_WAIT on imem_rsp_valid, go S_REQ and route {req_pc, data}: to IF/ID if (!id_valid | !stall), else to skid buffer.
REQ-019 SHALL, when id_valid & !stall and skid full, move skid into IF/ID (id_valid stays 1) and empty skid in the same cycle.
REQ-020 SHALL clear id_valid when id_valid & !stall and no new instruction is loaded that cycle.
REQ-021 SHALL hold id_pc/id_inst/id_valid unchanged while stall & id_valid.
REQ-022 SHALL treat branch_taken with priority over all other events: pc <= {branch_target[31:2], 2'b00}; id_valid <= 0; skid emptied; id_inst <= NOP.
REQ-023 SHALL set a drop flag when branch_taken occurs in S_WAIT without rsp_valid, or coincides with a request handshake; next response discarded, flag cleared, state S_REQ.
REQ-024 SHALL discard a response arriving in the same cycle as branch_taken (no drop flag set).
REQ-025 SHALL ignore imem_rsp_valid in S_REQ.
REQ-026 SHALL latency: response cycle N -> id_valid high at N+1 when IF/ID free.

Reset
REQ-027 SHALL on rst: pc = RESET_PC, state S_REQ, imem_req_valid = 0 during reset cycle, id_valid = 0, id_pc = 0, id_inst = 32'h0000_0013 (NOP), skid empty, drop flag clear.
REQ-028 SHALL abandon any outstanding request on rst; instruction memory shares the same rst.
REQ-029 SHALL issue first request (addr RESET_PC) in the first cycle after rst deasserts.

Structure
REQ-030 SHALL take from shared package riscv_pkg: opcode constants (I, I-arith, S, SB), NOP encoding 32'h0000_0013, FSM state encoding.
REQ-031 SHALL place the one-entry skid buffer in sub-module fetch_skid (valid, pc, inst; load/unload/flush).

Verification
REQ-032 SHALL test: reset, ready=1, 1-cycle memory -> addrs 0x0,0x4,0x8; id_pc sequence 0x0,0x4,0x8; id_inst matches memory.
REQ-033 SHALL test: stall held 3 cycles with response arriving -> id_* frozen, skid holds next word, released in order, none lost/duplicated.
REQ-034 SHALL test: branch_taken (target 0x103) while S_WAIT -> late response dropped, next addr 0x100, id_valid 0 until 0x100 word.
REQ-035 SHALL test: imem_req_ready low 4 cycles -> req_valid/addr stable, pc not incremented.
REQ-036 SHALL test: RESET_PC = 0xFFFF_FFF8 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-037 SHALL test: rst asserted mid-S_WAIT with stall high -> all outputs return to REQ-027 values next cycle.
